spi_pixel_unpacker: RTL and testbench

- Sits directly downstream of the SPI byte receiver.
- Consumes a stream of received bytes (one per valid strobe) and parses a framed RGB protocol.
- Issues 24-bit pixel writes into a double-banked LED frame buffer RAM.
- Flips the display bank when a complete frame has arrived; the panel scan logic always reads the bank the unpacker is not writing.

---
 rtl/ledpi_pkg.sv | 22 ++
 rtl/spi_pixel_unpacker.sv | 134 +++++++++++++
 tb/tb_spi_pixel_unpacker.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ledpi_pkg.sv
//------------------------------------------------------------------------------
// ledpi_pkg
//   Shared definitions for the LED panel pixel path.
//   - SYNC_BYTE_DEFAULT : frame start marker used by the SPI pixel unpacker
//   - COLOR_W / RGB_W   : width of one colour channel and of a packed RGB pixel
//   - state_t           : unpacker FSM states
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package ledpi_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         COLOR_W           = 8;
  localparam int         RGB_W             = 3 * COLOR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_R = 2'd1,
    GET_G = 2'd2,
    GET_B = 2'd3
  } state_t;

endpackage

// File: rtl/spi_pixel_unpacker.sv
//------------------------------------------------------------------------------
// spi_pixel_unpacker
//   Parses a framed RGB byte stream from the SPI byte receiver and writes
//   24-bit pixels into a double-banked frame buffer. A frame is SYNC_BYTE
//   followed by NUM_PIXELS R,G,B triplets. Writes go to the hidden bank
//   (~disp_bank); when the last pixel is written the display bank flips.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   byte_valid  one-cycle strobe, byte_data holds a new byte
//   byte_data   received byte
//   link_idle   one-cycle pulse at SPI transaction end (aborts a partial frame)
//   wr_en       frame buffer write strobe (one cycle per pixel)
//   wr_addr     {write bank, pixel index}
//   wr_data     {R,G,B}
//   disp_bank   bank the panel scanner reads
//   frame_done  one-cycle pulse, issued with the last write of a frame
//   frame_err   one-cycle pulse when a partial frame is aborted
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_pixel_unpacker
  import ledpi_pkg::*;
#(
  parameter int          NUM_PIXELS = 512,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  localparam int         ADDR_W     = $clog2(NUM_PIXELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              link_idle,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [RGB_W-1:0]  wr_data,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  state_t               state_reg;
  logic [ADDR_W-1:0]    idx_reg;
  logic [COLOR_W-1:0]   r_reg;
  logic [COLOR_W-1:0]   g_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      r_reg      <= '0;
      g_reg      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      disp_bank  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Strobes default low; each is asserted for a single cycle below.
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      case (state_reg)
        IDLE: begin
          // link_idle is meaningless here; only the sync marker starts a frame.
          if (byte_valid && (byte_data == SYNC_BYTE)) begin
            state_reg <= GET_R;
            idx_reg   <= '0;
          end
        end

        GET_R: begin
          // Abort takes priority over a colliding R byte.
          if (link_idle) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            frame_err <= 1'b1;
          end else if (byte_valid) begin
            r_reg     <= byte_data;
            state_reg <= GET_G;
          end
        end

        GET_G: begin
          if (link_idle) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            frame_err <= 1'b1;
          end else if (byte_valid) begin
            g_reg     <= byte_data;
            state_reg <= GET_B;
          end
        end

        GET_B: begin
          if (byte_valid) begin
            // The B byte is always consumed, even if link_idle arrives with it.
            // The write uses the bank as it was before any flip this cycle.
            wr_en   <= 1'b1;
            wr_data <= {r_reg, g_reg, byte_data};
            wr_addr <= {~disp_bank, idx_reg};
            if (idx_reg == LAST_IDX) begin
              frame_done <= 1'b1;
              disp_bank  <= ~disp_bank;
              idx_reg    <= '0;
              state_reg  <= IDLE;
            end else if (link_idle) begin
              frame_err <= 1'b1;
              idx_reg   <= '0;
              state_reg <= IDLE;
            end else begin
              idx_reg   <= idx_reg + ADDR_W'(1);
              state_reg <= GET_R;
            end
          end else if (link_idle) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            frame_err <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          idx_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pixel_unpacker.sv
//------------------------------------------------------------------------------
// tb_spi_pixel_unpacker
//   Directed bench for spi_pixel_unpacker with NUM_PIXELS=4 (ADDR_W=2, so
//   wr_addr is 3 bits: bank 1 addresses are 4..7, bank 0 addresses 0..3).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_pixel_unpacker;

  localparam int         NP     = 4;
  localparam int         AW     = 2;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic          clk;
  logic          rst_n;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          link_idle;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [23:0]   wr_data;
  logic          disp_bank;
  logic          frame_done;
  logic          frame_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  spi_pixel_unpacker #(
    .NUM_PIXELS (NP),
    .SYNC_BYTE  (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .link_idle  (link_idle),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .disp_bank  (disp_bank),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and output monitor (outputs sampled on the falling edge).
  int          cyc = 0;
  logic [AW:0] w_addr_q[$];
  logic [23:0] w_data_q[$];
  int          w_cyc_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          err_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      w_addr_q.push_back(wr_addr);
      w_data_q.push_back(wr_data);
      w_cyc_q.push_back(cyc);
      $display("write addr=%h data=%h cyc=%0d", wr_addr, wr_data, cyc);
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    link_idle  = 1'b0;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    byte_valid = 1'b0;
    link_idle  = 1'b0;
  endtask

  task automatic pulse_idle();
    @(negedge clk);
    byte_valid = 1'b0;
    link_idle  = 1'b1;
    @(negedge clk);
    link_idle  = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // Sync byte plus 12 data bytes base, base+1, ... base+11.
  task automatic send_frame(input logic [7:0] base);
    send_byte(SYNC);
    for (int i = 0; i < 3*NP; i++) send_byte(base + 8'(i));
    idle_bus();
    settle();
  endtask

  function automatic logic [23:0] pix(input logic [7:0] base, input int i);
    logic [7:0] c;
    c = base + 8'(3*i);
    return {c, c + 8'd1, c + 8'd2};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", wr_en); else pass_cnt++;
    total_cnt++; if (wr_addr !== '0) $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); else pass_cnt++;
    total_cnt++; if (wr_data !== '0) $display("FAIL reset_wr_data: got %h expected 0", wr_data); else pass_cnt++;
    total_cnt++; if (disp_bank !== 1'b0) $display("FAIL reset_disp_bank: got %b expected 0", disp_bank); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", frame_done); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    int wb = w_addr_q.size();
    int db = done_cnt;
    int eb = err_cnt;
    send_frame(8'h01);
    total_cnt++; if (w_addr_q.size() - wb !== 4) $display("FAIL t1_count: got %0d expected 4", w_addr_q.size() - wb); else pass_cnt++;
    for (int i = 0; i < NP; i++) begin
      total_cnt++; if (w_addr_q[wb+i] !== 3'(4 + i)) $display("FAIL t1_addr[%0d]: got %h expected %h", i, w_addr_q[wb+i], 3'(4 + i)); else pass_cnt++;
      total_cnt++; if (w_data_q[wb+i] !== pix(8'h01, i)) $display("FAIL t1_data[%0d]: got %h expected %h", i, w_data_q[wb+i], pix(8'h01, i)); else pass_cnt++;
    end
    total_cnt++; if (done_cnt - db !== 1) $display("FAIL t1_done_cnt: got %0d expected 1", done_cnt - db); else pass_cnt++;
    total_cnt++; if (done_cyc !== w_cyc_q[wb+3]) $display("FAIL t1_done_align: got cyc %0d expected %0d", done_cyc, w_cyc_q[wb+3]); else pass_cnt++;
    total_cnt++; if (err_cnt - eb !== 0) $display("FAIL t1_err_cnt: got %0d expected 0", err_cnt - eb); else pass_cnt++;
    total_cnt++; if (disp_bank !== 1'b1) $display("FAIL t1_disp_bank: got %b expected 1", disp_bank); else pass_cnt++;
  endtask

  task automatic test_garbage();
    int wb = w_addr_q.size();
    int db = done_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle_bus();
    settle();
    total_cnt++; if (w_addr_q.size() - wb !== 0) $display("FAIL t2_garbage_writes: got %0d expected 0", w_addr_q.size() - wb); else pass_cnt++;
    send_frame(8'h01);
    total_cnt++; if (w_addr_q.size() - wb !== 4) $display("FAIL t2_count: got %0d expected 4", w_addr_q.size() - wb); else pass_cnt++;
    for (int i = 0; i < NP; i++) begin
      total_cnt++; if (w_addr_q[wb+i] !== 3'(i)) $display("FAIL t2_addr[%0d]: got %h expected %h", i, w_addr_q[wb+i], 3'(i)); else pass_cnt++;
      total_cnt++; if (w_data_q[wb+i] !== pix(8'h01, i)) $display("FAIL t2_data[%0d]: got %h expected %h", i, w_data_q[wb+i], pix(8'h01, i)); else pass_cnt++;
    end
    total_cnt++; if (done_cnt - db !== 1) $display("FAIL t2_done_cnt: got %0d expected 1", done_cnt - db); else pass_cnt++;
    total_cnt++; if (disp_bank !== 1'b0) $display("FAIL t2_disp_bank: got %b expected 0", disp_bank); else pass_cnt++;
  endtask

  task automatic test_abort();
    int wb = w_addr_q.size();
    int db = done_cnt;
    int eb = err_cnt;
    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    pulse_idle();
    settle();
    total_cnt++; if (w_addr_q.size() - wb !== 1) $display("FAIL t3_count: got %0d expected 1", w_addr_q.size() - wb); else pass_cnt++;
    total_cnt++; if (w_addr_q[wb] !== 3'd4) $display("FAIL t3_addr: got %h expected 4", w_addr_q[wb]); else pass_cnt++;
    total_cnt++; if (w_data_q[wb] !== 24'h112233) $display("FAIL t3_data: got %h expected 112233", w_data_q[wb]); else pass_cnt++;
    total_cnt++; if (err_cnt - eb !== 1) $display("FAIL t3_err_cnt: got %0d expected 1", err_cnt - eb); else pass_cnt++;
    total_cnt++; if (done_cnt - db !== 0) $display("FAIL t3_done_cnt: got %0d expected 0", done_cnt - db); else pass_cnt++;
    total_cnt++; if (disp_bank !== 1'b0) $display("FAIL t3_disp_bank: got %b expected 0", disp_bank); else pass_cnt++;
    // Restart from pixel 0 after the abort.
    wb = w_addr_q.size();
    send_frame(8'h21);
    total_cnt++; if (w_addr_q.size() - wb !== 4) $display("FAIL t3_restart_count: got %0d expected 4", w_addr_q.size() - wb); else pass_cnt++;
    total_cnt++; if (w_addr_q[wb] !== 3'd4) $display("FAIL t3_restart_addr: got %h expected 4", w_addr_q[wb]); else pass_cnt++;
    total_cnt++; if (w_data_q[wb] !== 24'h212223) $display("FAIL t3_restart_data: got %h expected 212223", w_data_q[wb]); else pass_cnt++;
    total_cnt++; if (disp_bank !== 1'b1) $display("FAIL t3_restart_disp_bank: got %b expected 1", disp_bank); else pass_cnt++;
  endtask

  task automatic test_collision();
    int wb = w_addr_q.size();
    int db = done_cnt;
    int eb = err_cnt;
    // link_idle together with the final B byte: write and frame_done, no error.
    send_byte(SYNC);
    for (int i = 0; i < 3*NP-1; i++) send_byte(8'h81 + 8'(i));
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h8C;
    link_idle  = 1'b1;
    idle_bus();
    settle();
    total_cnt++; if (w_addr_q.size() - wb !== 4) $display("FAIL t4_last_count: got %0d expected 4", w_addr_q.size() - wb); else pass_cnt++;
    total_cnt++; if (w_addr_q[wb+3] !== 3'd3) $display("FAIL t4_last_addr: got %h expected 3", w_addr_q[wb+3]); else pass_cnt++;
    total_cnt++; if (w_data_q[wb+3] !== 24'h8A8B8C) $display("FAIL t4_last_data: got %h expected 8a8b8c", w_data_q[wb+3]); else pass_cnt++;
    total_cnt++; if (done_cnt - db !== 1) $display("FAIL t4_last_done: got %0d expected 1", done_cnt - db); else pass_cnt++;
    total_cnt++; if (err_cnt - eb !== 0) $display("FAIL t4_last_err: got %0d expected 0", err_cnt - eb); else pass_cnt++;
    total_cnt++; if (disp_bank !== 1'b0) $display("FAIL t4_last_disp_bank: got %b expected 0", disp_bank); else pass_cnt++;
    // link_idle together with a G byte: byte dropped, frame aborted.
    wb = w_addr_q.size();
    db = done_cnt;
    eb = err_cnt;
    send_byte(SYNC);
    send_byte(8'h55);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h66;
    link_idle  = 1'b1;
    // Had the G byte been accepted this B byte would produce a write.
    send_byte(8'h77);
    idle_bus();
    settle();
    total_cnt++; if (w_addr_q.size() - wb !== 0) $display("FAIL t4_g_writes: got %0d expected 0", w_addr_q.size() - wb); else pass_cnt++;
    total_cnt++; if (err_cnt - eb !== 1) $display("FAIL t4_g_err: got %0d expected 1", err_cnt - eb); else pass_cnt++;
    total_cnt++; if (done_cnt - db !== 0) $display("FAIL t4_g_done: got %0d expected 0", done_cnt - db); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int wb = w_addr_q.size();
    int db = done_cnt;
    int exp_cyc[$];
    logic [7:0] base [2];
    base[0] = 8'h31;
    base[1] = 8'h41;
    for (int f = 0; f < 2; f++) begin
      send_byte(SYNC);
      for (int i = 0; i < 3*NP; i++) begin
        send_byte(base[f] + 8'(i));
        if (i % 3 == 2) exp_cyc.push_back(cyc + 1);
      end
    end
    idle_bus();
    settle();
    total_cnt++; if (w_addr_q.size() - wb !== 8) $display("FAIL t5_count: got %0d expected 8", w_addr_q.size() - wb); else pass_cnt++;
    for (int k = 0; k < 2*NP; k++) begin
      logic [AW:0] ea;
      ea = (k < NP) ? 3'(4 + k) : 3'(k - NP);
      total_cnt++; if (w_addr_q[wb+k] !== ea) $display("FAIL t5_addr[%0d]: got %h expected %h", k, w_addr_q[wb+k], ea); else pass_cnt++;
      total_cnt++; if (w_data_q[wb+k] !== pix(base[k/NP], k % NP)) $display("FAIL t5_data[%0d]: got %h expected %h", k, w_data_q[wb+k], pix(base[k/NP], k % NP)); else pass_cnt++;
      total_cnt++; if (w_cyc_q[wb+k] !== exp_cyc[k]) $display("FAIL t5_latency[%0d]: got cyc %0d expected %0d", k, w_cyc_q[wb+k], exp_cyc[k]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt - db !== 2) $display("FAIL t5_done_cnt: got %0d expected 2", done_cnt - db); else pass_cnt++;
    total_cnt++; if (disp_bank !== 1'b0) $display("FAIL t5_disp_bank: got %b expected 0", disp_bank); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int wb;
    send_frame(8'h51);   // leaves disp_bank=1 and wr_addr=7
    wb = w_addr_q.size();
    send_byte(SYNC);
    send_byte(8'h61);
    idle_bus();          // R consumed, now waiting for G
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL t6_wr_en: got %b expected 0", wr_en); else pass_cnt++;
    total_cnt++; if (wr_addr !== '0) $display("FAIL t6_wr_addr: got %h expected 0", wr_addr); else pass_cnt++;
    total_cnt++; if (wr_data !== '0) $display("FAIL t6_wr_data: got %h expected 0", wr_data); else pass_cnt++;
    total_cnt++; if (disp_bank !== 1'b0) $display("FAIL t6_disp_bank: got %b expected 0", disp_bank); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0 || frame_err !== 1'b0) $display("FAIL t6_pulses: got %b%b expected 00", frame_done, frame_err); else pass_cnt++;
    send_byte(8'h62);    // ignored while in reset
    idle_bus();
    rst_n = 1'b1;
    settle();
    total_cnt++; if (w_addr_q.size() - wb !== 0) $display("FAIL t6_spurious: got %0d expected 0", w_addr_q.size() - wb); else pass_cnt++;
    send_frame(8'h71);
    total_cnt++; if (w_addr_q.size() - wb !== 4) $display("FAIL t6_count: got %0d expected 4", w_addr_q.size() - wb); else pass_cnt++;
    for (int i = 0; i < NP; i++) begin
      total_cnt++; if (w_addr_q[wb+i] !== 3'(4 + i)) $display("FAIL t6_addr[%0d]: got %h expected %h", i, w_addr_q[wb+i], 3'(4 + i)); else pass_cnt++;
      total_cnt++; if (w_data_q[wb+i] !== pix(8'h71, i)) $display("FAIL t6_data[%0d]: got %h expected %h", i, w_data_q[wb+i], pix(8'h71, i)); else pass_cnt++;
    end
    total_cnt++; if (disp_bank !== 1'b1) $display("FAIL t6_disp_bank_end: got %b expected 1", disp_bank); else pass_cnt++;
  endtask

  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    link_idle  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_garbage();
    test_abort();
    test_collision();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
